gabor_conv_engine: RTL and testbench

GABOR_CONV_ENGINE -- requirements
Module: gabor_conv_engine

---
 rtl/gabor_conv_engine.sv | 162 ++++++++++++++++
 tb/tb_gabor_conv_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gabor_conv_engine.sv
// Streaming KSIZE x KSIZE signed-coefficient convolution over a raster frame.
// Valid-only output positions, fixed-point rescale, optional magnitude, saturation.
//
// state | meaning
// IDLE  | waiting for start; coefficient bank writable
// RUN   | accepting pixels, producing results
// DRAIN | all pixels taken, waiting for last result to be consumed
// DONE  | one-cycle frame-complete pulse
module gabor_conv_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int FRAC_W = 12,
  parameter int KSIZE  = 3,
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int OUT_W  = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  abs_mode,
  input  logic                                  coef_we,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0]              coef_data,
  input  logic                                  pix_valid,
  input  logic [DATA_W-1:0]                     pix_data,
  output logic                                  pix_ready,
  output logic                                  res_valid,
  output logic signed [OUT_W-1:0]               res_data,
  input  logic                                  res_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int NCOEF  = KSIZE * KSIZE;
  localparam int AW     = $clog2(NCOEF);
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int SUM_W  = PROD_W + $clog2(NCOEF);
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);

  localparam logic [AW:0]   NCOEF_C  = (AW+1)'(NCOEF);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_K    = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_K    = RW'(KSIZE - 1);
  localparam logic signed [SUM_W-1:0] OMAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] OMIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nx;

  logic signed [COEF_W-1:0] coef [NCOEF];
  logic [DATA_W-1:0]        lbuf [KSIZE-1][IMG_W];
  logic [DATA_W-1:0]        win  [KSIZE][KSIZE];
  logic [DATA_W-1:0]        nwin [KSIZE][KSIZE];
  logic [DATA_W-1:0]        col_vec [KSIZE];
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic                     abs_q;
  logic                     accept, produce, last_pix;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  acc, shifted, mag;
  logic signed [OUT_W-1:0]  sat;

  assign pix_ready = (state == RUN) && (!res_valid || res_ready);
  assign accept    = pix_valid && pix_ready;
  assign produce   = (row >= ROW_K) && (col >= COL_K);
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == DONE);
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (accept && last_pix) state_nx = DRAIN;
      DRAIN:   if (!res_valid) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCOEF; k++) coef[k] <= '0;
    end else if (coef_we && (state == IDLE) && ({1'b0, coef_addr} < NCOEF_C)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Next window = current window shifted left with the incoming column on the right;
  // the result is computed from it so it lands one edge after acceptance.
  always_comb begin
    col_vec = '{default: '0};
    nwin    = '{default: '0};
    for (int i = 0; i < KSIZE-1; i++) col_vec[i] = lbuf[i][col];
    col_vec[KSIZE-1] = pix_data;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE-1; j++) nwin[i][j] = win[i][j+1];
      nwin[i][KSIZE-1] = col_vec[i];
    end
    acc  = '0;
    prod = '0;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        prod = $signed({1'b0, nwin[i][j]}) * coef[i*KSIZE + j];
        acc  = acc + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
      end
    end
    shifted = acc >>> FRAC_W;
    mag     = (abs_q && shifted[SUM_W-1]) ? -shifted : shifted;
    if (mag > OMAX)      sat = OMAX[OUT_W-1:0];
    else if (mag < OMIN) sat = OMIN[OUT_W-1:0];
    else                 sat = mag[OUT_W-1:0];
  end

  // Pixel storage needs no reset: a window is only used once filled from the current frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < KSIZE-2; i++) lbuf[i][col] <= lbuf[i+1][col];
      lbuf[KSIZE-2][col] <= pix_data;
      win <= nwin;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      abs_q     <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        col   <= '0;
        row   <= '0;
        abs_q <= abs_mode;
      end else if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept && produce) begin
        res_valid <= 1'b1;
        res_data  <= sat;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gabor_conv_engine.sv
// Directed scoreboard bench: two engines (FRAC_W 12 and 0) share stimulus on a 4x4 frame.
module tb_gabor_conv_engine;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int K  = 3;

  logic clk = 1'b0;
  logic reset, start, abs_mode, coef_we, pix_valid, res_ready;
  logic [3:0] coef_addr;
  logic signed [15:0] coef_data;
  logic [7:0] pix_data;
  logic pix_ready0, res_valid0, busy0, done0;
  logic pix_ready1, res_valid1, busy1, done1;
  logic signed [15:0] res_data0, res_data1;

  int errors = 0;
  int checks = 0;
  int exp0[$];
  int exp1[$];
  int coef_m[K*K];
  int img[IW*IH];

  always #5 clk = ~clk;

  gabor_conv_engine #(.DATA_W(8), .COEF_W(16), .FRAC_W(12), .KSIZE(K),
                      .IMG_W(IW), .IMG_H(IH), .OUT_W(16)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abs_mode(abs_mode), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready0), .res_valid(res_valid0), .res_data(res_data0), .res_ready(res_ready),
    .busy(busy0), .done(done0));

  gabor_conv_engine #(.DATA_W(8), .COEF_W(16), .FRAC_W(0), .KSIZE(K),
                      .IMG_W(IW), .IMG_H(IH), .OUT_W(16)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abs_mode(abs_mode), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready1), .res_valid(res_valid1), .res_data(res_data1), .res_ready(res_ready),
    .busy(busy1), .done(done1));

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int model(input int r, input int c, input int frac, input bit absm);
    int s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += coef_m[i*K + j] * img[(r-K+1+i)*IW + (c-K+1+j)];
    s = s >>> frac;
    if (absm && s < 0) s = -s;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Scoreboard: compare each consumed result against the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (res_valid0 && res_ready) begin
      if (exp0.size() > 0) chk("res0", int'(res_data0), exp0.pop_front());
      else chk("res0_unexpected", int'(res_valid0), 0);
    end
    if (res_valid1 && res_ready) begin
      if (exp1.size() > 0) chk("res1", int'(res_data1), exp1.pop_front());
      else chk("res1_unexpected", int'(res_valid1), 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pix_ready"}, int'(pix_ready0), 0);
    chk({tag, "_res_valid"}, int'(res_valid0), 0);
    chk({tag, "_res_data"},  int'(res_data0), 0);
    chk({tag, "_busy"},      int'(busy0), 0);
    chk({tag, "_done"},      int'(done0), 0);
  endtask

  task automatic wr(input int k, input int v, input bit model_upd);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 4'(k); coef_data = 16'(v);
    if (model_upd) coef_m[k] = v;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic wr_all(input int v);
    for (int k = 0; k < K*K; k++) wr(k, v, 1'b1);
  endtask

  task automatic img_ramp();
    for (int n = 0; n < IW*IH; n++) img[n] = n;
  endtask

  task automatic img_const(input int v);
    for (int n = 0; n < IW*IH; n++) img[n] = v;
  endtask

  task automatic run_frame(input bit absm, input bit stall, input bit run_wr);
    int idx = 0;
    int guard = 0;
    int dcount = 0;
    bit stalled = 1'b0;
    int held;
    @(negedge clk); start = 1'b1; abs_mode = absm;
    @(negedge clk); start = 1'b0; abs_mode = 1'b0;
    #1 chk("busy_run", int'(busy0), 1);
    if (run_wr) wr(4, 16'h7000, 1'b0);
    while (idx < IW*IH && guard < 300) begin
      @(negedge clk); guard++;
      if (stall && !stalled && res_valid0) begin
        stalled = 1'b1;
        res_ready = 1'b0;
        #1 held = int'(res_data0);
        for (int s = 0; s < 5; s++) begin
          #1 chk("bp_pix_ready", int'(pix_ready0), 0);
          chk("bp_res_hold", int'(res_data0), held);
          chk("bp_res_valid", int'(res_valid0), 1);
          @(negedge clk);
        end
        res_ready = 1'b1;
      end
      pix_valid = 1'b1;
      pix_data  = 8'(img[idx]);
      #1;
      if (pix_ready0) begin
        if (idx / IW >= K-1 && idx % IW >= K-1) begin
          exp0.push_back(model(idx / IW, idx % IW, 12, absm));
          exp1.push_back(model(idx / IW, idx % IW, 0, absm));
        end
        idx++;
      end
    end
    chk("feed_count", idx, IW*IH);
    @(negedge clk); pix_valid = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      #3;
      if (done0) begin
        dcount++;
        chk("done_after_last", exp0.size(), 0);
      end
    end
    chk("done_pulses", dcount, 1);
    chk("queue0_empty", exp0.size(), 0);
    chk("queue1_empty", exp1.size(), 0);
    chk("busy_idle", int'(busy0), 0);
  endtask

  initial begin
    int idx;
    int guard;
    reset = 1'b0; start = 1'b0; abs_mode = 1'b0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; pix_valid = 1'b0; pix_data = '0; res_ready = 1'b1;
    for (int k = 0; k < K*K; k++) coef_m[k] = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;

    // Coefficients start at zero after reset.
    img_ramp();
    run_frame(1'b0, 1'b0, 1'b0);

    // Identity kernel, ramp image: 5, 6, 9, 10 (and saturated x4096 on the FRAC 0 engine).
    wr(4, 4096, 1'b1);
    run_frame(1'b0, 1'b0, 1'b0);

    // Box filters.
    img_const(255);
    wr_all(4096);
    run_frame(1'b0, 1'b0, 1'b0);
    wr_all(-4096);
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b1, 1'b0, 1'b0);

    // Saturation extremes.
    wr_all(32767);
    run_frame(1'b0, 1'b0, 1'b0);
    wr_all(-32768);
    run_frame(1'b0, 1'b0, 1'b0);

    // Backpressure on the identity frame.
    img_ramp();
    wr_all(0);
    wr(4, 4096, 1'b1);
    run_frame(1'b0, 1'b1, 1'b0);

    // Reset after 7 pixels, then a fresh identity frame with a write attempted mid-run.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idx = 0; guard = 0;
    while (idx < 7 && guard < 50) begin
      @(negedge clk); guard++;
      pix_valid = 1'b1; pix_data = 8'(img[idx]);
      #1 if (pix_ready0) idx++;
    end
    chk("partial_feed", idx, 7);
    @(negedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs("midreset");
    pix_valid = 1'b0;
    exp0.delete(); exp1.delete();
    for (int k = 0; k < K*K; k++) coef_m[k] = 0;
    @(negedge clk); reset = 1'b1;
    wr(4, 4096, 1'b1);
    run_frame(1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
